// File: rtl/collision_search_array.sv
// Multi-lane SHA-1 collision searcher: feeds LANES sha1 cores in lockstep, each lane
// hashing the shared message with its own counter, and reports the lowest-lane hit.
module collision_search_array #(
   parameter int LANES = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic [4:0]             target,
   input  logic [511:0]           message,
   input  logic [31:0]            counter,
   input  logic [31:0]            increment,
   input  logic [31:0]            max_iter,
   output logic [LANES-1:0]       sha_initial,
   output logic [LANES-1:0]       sha_valid,
   output logic [32*LANES-1:0]    sha_data,
   input  logic [LANES-1:0]       sha_ready,
   input  logic [160*LANES-1:0]   sha_digest,
   output logic                   busy,
   output logic                   done,
   output logic                   found,
   output logic [3:0]             lane_id,
   output logic [31:0]            result,
   output logic [31:0]            digests_computed
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_CHECK, S_DONE} state_e;

   state_e                  state_q, state_d;
   logic [3:0]              word_idx_q, word_idx_d;
   logic [4:0]              target_q, target_d;
   logic [511:0]            msg_q, msg_d;
   logic [31:0]             inc_q, inc_d;
   logic [31:0]             max_iter_q, max_iter_d;
   logic [31:0]             base_q, base_d;
   logic [LANES-1:0][31:0]  lane_cnt_q, lane_cnt_d;
   logic [LANES-1:0]        seen_low_q, seen_low_d;
   logic [LANES-1:0]        lane_done_q, lane_done_d;
   logic                    found_q, found_d;
   logic [3:0]              lane_id_q, lane_id_d;
   logic [31:0]             result_q, result_d;
   logic [31:0]             dig_q, dig_d;
   logic [LANES-1:0]        sha_initial_q, sha_initial_d;
   logic [LANES-1:0]        sha_valid_q, sha_valid_d;
   logic [32*LANES-1:0]     sha_data_q, sha_data_d;

   // Hit detection and lowest-lane arbitration over the current digests.
   logic [159:0]            zero_mask;
   logic [LANES-1:0]        hit;
   logic                    win_found;
   logic [3:0]              win_idx;
   logic [31:0]             win_cnt;
   logic [32:0]             dig_sum;
   logic [31:0]             dig_sat;
   logic [31:0]             step;
   int                      word_lo;

   assign step = 32'(LANES) * inc_q;

   always_comb begin
      zero_mask = ~({160{1'b1}} >> target_q);
      hit       = '0;
      win_found = 1'b0;
      win_idx   = '0;
      win_cnt   = '0;
      for (int i = 0; i < LANES; i++) begin
         hit[i] = (sha_digest[160*i +: 160] & zero_mask) == 160'd0;
      end
      for (int i = LANES - 1; i >= 0; i--) begin
         if (hit[i]) begin
            win_found = 1'b1;
            win_idx   = 4'(i);
            win_cnt   = lane_cnt_q[i];
         end
      end
      dig_sum = {1'b0, dig_q} + 33'(LANES);
      dig_sat = dig_sum[32] ? 32'hFFFF_FFFF : dig_sum[31:0];
   end

   always_comb begin
      // NOTE: every next-state signal takes its held value first so no path infers a latch.
      state_d       = state_q;
      word_idx_d    = word_idx_q;
      target_d      = target_q;
      msg_d         = msg_q;
      inc_d         = inc_q;
      max_iter_d    = max_iter_q;
      base_d        = base_q;
      lane_cnt_d    = lane_cnt_q;
      seen_low_d    = seen_low_q;
      lane_done_d   = lane_done_q;
      found_d       = found_q;
      lane_id_d     = lane_id_q;
      result_d      = result_q;
      dig_d         = dig_q;
      sha_initial_d = '0;
      sha_valid_d   = '0;
      sha_data_d    = sha_data_q;
      word_lo       = 448 - 32 * int'(word_idx_q);

      // A core has finished once its ready has dropped and come back.
      if (state_q == S_LOAD || state_q == S_WAIT) begin
         if (state_q == S_LOAD && word_idx_q == 4'd0) begin
            seen_low_d  = '0;
            lane_done_d = '0;
         end else begin
            for (int i = 0; i < LANES; i++) begin
               if (!sha_ready[i]) seen_low_d[i] = 1'b1;
               if (sha_ready[i] && seen_low_q[i]) lane_done_d[i] = 1'b1;
            end
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               target_d   = target;
               msg_d      = message;
               inc_d      = increment;
               max_iter_d = max_iter;
               base_d     = counter;
               found_d    = 1'b0;
               lane_id_d  = '0;
               result_d   = '0;
               dig_d      = '0;
               word_idx_d = '0;
               sha_initial_d = '1;
               sha_valid_d   = '1;
               for (int i = 0; i < LANES; i++) begin
                  lane_cnt_d[i]         = counter + 32'(i) * increment;
                  sha_data_d[32*i +: 32] = counter + 32'(i) * increment;
               end
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (abort) begin
               found_d  = 1'b0;
               result_d = base_q;
               state_d  = S_DONE;
            end else if (word_idx_q == 4'd15) begin
               state_d = S_WAIT;
            end else begin
               word_idx_d  = word_idx_q + 4'd1;
               sha_valid_d = '1;
               for (int i = 0; i < LANES; i++) begin
                  sha_data_d[32*i +: 32] = msg_q[word_lo +: 32];
               end
            end
         end
         S_WAIT: begin
            if (abort) begin
               found_d  = 1'b0;
               result_d = base_q;
               state_d  = S_DONE;
            end else if (&lane_done_q) begin
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            dig_d = dig_sat;
            if (abort) begin
               found_d  = 1'b0;
               result_d = base_q;
               state_d  = S_DONE;
            end else if (win_found) begin
               found_d   = 1'b1;
               lane_id_d = win_idx;
               result_d  = win_cnt;
               state_d   = S_DONE;
            end else if (max_iter_q != 32'd0 && dig_sat >= max_iter_q) begin
               found_d  = 1'b0;
               result_d = base_q + step;
               state_d  = S_DONE;
            end else begin
               base_d        = base_q + step;
               word_idx_d    = '0;
               sha_initial_d = '1;
               sha_valid_d   = '1;
               for (int i = 0; i < LANES; i++) begin
                  lane_cnt_d[i]          = lane_cnt_q[i] + step;
                  sha_data_d[32*i +: 32] = lane_cnt_q[i] + step;
               end
               state_d = S_LOAD;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: the latched message is reset too, so nothing left over from an aborted search is visible.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         word_idx_q    <= '0;
         target_q      <= '0;
         msg_q         <= '0;
         inc_q         <= '0;
         max_iter_q    <= '0;
         base_q        <= '0;
         lane_cnt_q    <= '0;
         seen_low_q    <= '0;
         lane_done_q   <= '0;
         found_q       <= 1'b0;
         lane_id_q     <= '0;
         result_q      <= '0;
         dig_q         <= '0;
         sha_initial_q <= '0;
         sha_valid_q   <= '0;
         sha_data_q    <= '0;
      end else begin
         state_q       <= state_d;
         word_idx_q    <= word_idx_d;
         target_q      <= target_d;
         msg_q         <= msg_d;
         inc_q         <= inc_d;
         max_iter_q    <= max_iter_d;
         base_q        <= base_d;
         lane_cnt_q    <= lane_cnt_d;
         seen_low_q    <= seen_low_d;
         lane_done_q   <= lane_done_d;
         found_q       <= found_d;
         lane_id_q     <= lane_id_d;
         result_q      <= result_d;
         dig_q         <= dig_d;
         sha_initial_q <= sha_initial_d;
         sha_valid_q   <= sha_valid_d;
         sha_data_q    <= sha_data_d;
      end
   end

   assign sha_initial      = sha_initial_q;
   assign sha_valid        = sha_valid_q;
   assign sha_data         = sha_data_q;
   assign busy             = (state_q != S_IDLE);
   assign done             = (state_q == S_DONE);
   assign found            = found_q;
   assign lane_id          = lane_id_q;
   assign result           = result_q;
   assign digests_computed = dig_q;

endmodule

// File: tb/tb_collision_search_array.sv
// Directed bench for collision_search_array with four behavioural sha1 lane models.
module tb_collision_search_array;

   localparam int LANES = 4;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  start, abort;
   logic [4:0]            target;
   logic [511:0]          message;
   logic [31:0]           counter, increment, max_iter;
   logic [LANES-1:0]      sha_initial, sha_valid, sha_ready;
   logic [32*LANES-1:0]   sha_data;
   logic [160*LANES-1:0]  sha_digest;
   logic                  busy, done, found;
   logic [3:0]            lane_id;
   logic [31:0]           result, digests_computed;

   int n_checks = 0;
   int n_err    = 0;

   collision_search_array #(.LANES(LANES)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .target(target),
      .message(message), .counter(counter), .increment(increment), .max_iter(max_iter),
      .sha_initial(sha_initial), .sha_valid(sha_valid), .sha_data(sha_data),
      .sha_ready(sha_ready), .sha_digest(sha_digest), .busy(busy), .done(done),
      .found(found), .lane_id(lane_id), .result(result),
      .digests_computed(digests_computed)
   );

   always #5 clk = ~clk;

   // Lane models: capture word 0, drop ready one cycle after word 15 for 80 cycles.
   logic [31:0]  zero_list[$];
   logic [31:0]  w0_log[$];
   logic [159:0] m_dig[LANES];
   int           m_wcnt[LANES];
   int           m_low[LANES];

   function automatic bit is_zero(input logic [31:0] c);
      foreach (zero_list[k]) if (zero_list[k] == c) return 1'b1;
      return 1'b0;
   endfunction

   for (genvar g = 0; g < LANES; g++) begin : g_dig
      assign sha_digest[160*g +: 160] = m_dig[g];
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         sha_ready <= '1;
         for (int i = 0; i < LANES; i++) begin
            m_dig[i]  <= '1;
            m_wcnt[i] <= 0;
            m_low[i]  <= 0;
         end
      end else begin
         for (int i = 0; i < LANES; i++) begin
            if (m_low[i] > 0) begin
               m_low[i] <= m_low[i] - 1;
               if (m_low[i] == 1) sha_ready[i] <= 1'b1;
            end
            if (sha_valid[i]) begin
               if (sha_initial[i]) begin
                  m_dig[i]  <= {is_zero(sha_data[32*i +: 32]) ? 8'h00 : 8'hFF, 152'h0};
                  m_wcnt[i] <= 1;
                  if (i == 0) w0_log.push_back(sha_data[31:0]);
               end else begin
                  if (m_wcnt[i] == 15) begin
                     sha_ready[i] <= 1'b0;
                     m_low[i]     <= 80;
                  end
                  m_wcnt[i] <= m_wcnt[i] + 1;
               end
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue a one-cycle start; returns at the negedge of the first LOAD cycle.
   task automatic go(input logic [31:0] cnt, input logic [31:0] inc,
                     input logic [4:0] tgt, input logic [31:0] mi);
      counter   = cnt;
      increment = inc;
      target    = tgt;
      max_iter  = mi;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, 32'(done), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      target = '0; counter = '0; increment = '0; max_iter = '0;
      for (int k = 0; k < 16; k++) message[511-32*k -: 32] = 32'hA000_0000 + 32'(k);
      repeat (3) @(negedge clk);
      check("rst_busy",   32'(busy), 32'd0);
      check("rst_done",   32'(done), 32'd0);
      check("rst_found",  32'(found), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_dig",    digests_computed, 32'd0);
      check("rst_valid",  32'(sha_valid), 32'd0);
      check("rst_data",   sha_data[31:0], 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // target 0: every digest hits, lane 0 wins on the first batch
      go(32'h10, 32'd1, 5'd0, 32'd0);
      check("a_init",  32'(sha_initial), 32'hF);
      check("a_valid", 32'(sha_valid), 32'hF);
      check("a_w0_l0", sha_data[31:0], 32'h10);
      check("a_w0_l3", sha_data[127:96], 32'h13);
      @(negedge clk);
      check("a_init2", 32'(sha_initial), 32'h0);
      check("a_w1_l0", sha_data[31:0], 32'hA000_0001);
      check("a_w1_l2", sha_data[95:64], 32'hA000_0001);
      wait_done("a");
      check("a_found",  32'(found), 32'd1);
      check("a_lane",   32'(lane_id), 32'd0);
      check("a_result", result, 32'h10);
      check("a_dig",    digests_computed, 32'd4);
      check("a_busy",   32'(busy), 32'd1);
      @(negedge clk);
      check("a_pulse",  32'(done), 32'd0);
      check("a_idle",   32'(busy), 32'd0);
      check("a_hold",   32'(found), 32'd1);

      // hit in the second batch on lane 2
      zero_list = '{32'h1006};
      go(32'h1000, 32'd1, 5'd8, 32'd0);
      wait_done("b");
      check("b_found",  32'(found), 32'd1);
      check("b_lane",   32'(lane_id), 32'd2);
      check("b_result", result, 32'h1006);
      check("b_dig",    digests_computed, 32'd8);
      @(negedge clk);

      // two hits in one batch, lowest lane wins; a start while busy is ignored
      zero_list = '{32'h1001, 32'h1002};
      go(32'h1000, 32'd1, 5'd8, 32'd0);
      repeat (30) @(negedge clk);
      counter = 32'h5000;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      wait_done("c");
      check("c_found",  32'(found), 32'd1);
      check("c_lane",   32'(lane_id), 32'd1);
      check("c_result", result, 32'h1001);
      check("c_dig",    digests_computed, 32'd4);
      @(negedge clk);

      // iteration limit with no hits
      zero_list = {};
      go(32'h1000, 32'd1, 5'd8, 32'd8);
      wait_done("d");
      check("d_found",  32'(found), 32'd0);
      check("d_result", result, 32'h1008);
      check("d_dig",    digests_computed, 32'd8);
      @(negedge clk);

      // counter wrap across the lanes and into the next batch
      w0_log.delete();
      go(32'hFFFF_FFFE, 32'd1, 5'd8, 32'd8);
      check("e_w0_l0", sha_data[31:0],   32'hFFFF_FFFE);
      check("e_w0_l1", sha_data[63:32],  32'hFFFF_FFFF);
      check("e_w0_l2", sha_data[95:64],  32'h0);
      check("e_w0_l3", sha_data[127:96], 32'h1);
      wait_done("e");
      check("e_batches", 32'(w0_log.size()), 32'd2);
      if (w0_log.size() == 2) check("e_b2_l0", w0_log[1], 32'h2);
      check("e_result", result, 32'h6);
      check("e_dig",    digests_computed, 32'd8);
      @(negedge clk);

      // abort during WAIT of the first batch
      go(32'h2000, 32'd1, 5'd8, 32'd0);
      repeat (30) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("f_done",   32'(done), 32'd1);
      check("f_found",  32'(found), 32'd0);
      check("f_result", result, 32'h2000);
      check("f_dig",    digests_computed, 32'd0);
      repeat (100) @(negedge clk);

      // reset in the middle of LOAD
      go(32'h3000, 32'd1, 5'd8, 32'd0);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      check("g_busy",  32'(busy), 32'd0);
      check("g_done",  32'(done), 32'd0);
      check("g_valid", 32'(sha_valid), 32'd0);
      check("g_data",  sha_data[31:0], 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("g_idle",  32'(busy), 32'd0);
      check("g_nodone", 32'(done), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/collision_search_array.md
# collision_search_array

Parametrised multi-lane successor of the single-core SHA-1 collision searcher. It drives LANES external sha1 cores in lockstep, and each lane hashes the shared 512-bit message with its own 32-bit counter in word 0. Digests are checked for `target` leading zero bits. The block adds lowest-lane hit arbitration, an iteration limit, abort, and found/exhausted status. It sits between the host register interface and the array of sha1 instances.

## Interface
- LANES, 4, number of sha1 cores driven in lockstep (1..16)
- clk  in  1  clock (all logic on posedge)
- reset  in  1  reset, asynchronous, active-high
- start  in  1  begin a search; sampled only in IDLE
- abort  in  1  terminate the search; honoured in LOAD, WAIT, CHECK
- target  in  5  required number of leading zero digest bits (0..31)
- message  in  512  base message; word k (k=1..15) = message[511-32k -: 32]
- counter  in  32  base counter value
- increment  in  32  counter step between consecutive candidates
- max_iter  in  32  digest limit; 0 = unlimited
- sha_initial  out  LANES  per-lane first-word strobe
- sha_valid  out  LANES  per-lane word valid
- sha_data  out  32*LANES  per-lane word; lane i at [32i+31:32i]
- sha_ready  in  LANES  per-lane core ready
- sha_digest  in  160*LANES  per-lane digest; lane i at [160i+159:160i]; valid while its ready=1
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle completion pulse
- found  out  1  the last search ended on a hit; held until next accepted start
- lane_id  out  4  hitting lane; held
- result  out  32  hit counter, or next untested base counter if no hit; held
- digests_computed  out  32  digests checked in the current/last search; held

## Operation
- States: IDLE, LOAD, WAIT, CHECK, DONE.
- IDLE: on start, latch target, message, increment, max_iter. Set lane i counter to counter + i*increment and base to counter. Clear found, lane_id, result, digests_computed. Go to LOAD. start while busy is ignored.
- LOAD: 16 cycles, word index 0..15, all lanes in parallel, sha_valid all ones.
  - Word 0 is the lane counter, with sha_initial all ones.
  - Words 1..15 come from the latched message.
  - Clear per-lane seen_low and done flags on the first LOAD cycle. Go to WAIT after word 15.
- Per-lane tracking, active in LOAD and WAIT: seen_low is set when sha_ready=0. done is set when sha_ready=1 and seen_low is already set.
- WAIT: when all lane done flags are set, go to CHECK.
- CHECK: hit_i = (target==0) or the top `target` bits of digest_i are all zero. digests_computed += LANES, saturating at 0xFFFFFFFF.
  - Any hit: the lowest index i wins. found=1, lane_id=i, result=lane i counter. Go to DONE.
  - Else, if max_iter≠0 and the updated count ≥ max_iter: found=0, result=base + LANES*increment. Go to DONE.
  - Else: every lane counter and base += LANES*increment. Go to LOAD.
- DONE: done=1 for one cycle, then IDLE.
- abort (priority over all CHECK outcomes): next state DONE, found=0, result=current base. digests_computed includes the batch only if abort is asserted in CHECK.
- Arithmetic: all counters are mod 2^32 (wrap silently). LANES*increment is truncated to 32 bits.

## Timing
- Reset: state IDLE; every output and internal register 0, including sha_*.
- start high in IDLE cycle T:
  - LOAD occupies T+1..T+16; sha_initial is high only at T+1.
  - WAIT is entered at T+17.
- CHECK is the cycle after the last lane done flag is registered. DONE is the cycle after CHECK. IDLE follows, and a new start is accepted there.
- Abort asserted in cycle A (non-IDLE, non-DONE) → done=1 at A+1.
- Reset mid-search → all outputs 0 immediately. No done pulse is generated.
- sha_valid/sha_data are registered outputs. No backpressure exists; cores must accept 16 consecutive words.

## Test plan
Bench uses LANES=4 and behavioural sha1 models. Each model drops ready 1 cycle after word 15 and restores it 80 cycles later. Its digest has top byte 0x00 only for listed counters, else 0xFF.
- target=0, counter=0x10, increment=1 → first CHECK: found=1, lane_id=0, result=0x10, digests_computed=4, done 1 cycle after CHECK.
- counter=0x1000, increment=1, target=8, zero-digest at 0x1006 → batch 2 carries lane counters 0x1004..0x1007. Expect found=1, lane_id=2, result=0x1006, digests_computed=8.
- zero-digests at 0x1001 and 0x1002 → lane_id=1, result=0x1001 (lowest lane wins).
- max_iter=8, no hits, counter=0x1000 → done after 2 batches: found=0, result=0x1008, digests_computed=8.
- counter=0xFFFFFFFE, increment=1 → word 0 per lane is 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1. The next batch starts at 0x2.
- abort during WAIT of batch 1 → done the next cycle, found=0, result=base, digests_computed=0. Separately, reset during LOAD → busy, done, sha_valid=0 at once. A start while busy is ignored.
